fetch_sequencer: RTL

- Instruction-fetch controller that owns the fetch program counter.
- Issues one instruction-memory request at a time over a valid/ready channel and presents each returned instruction, with its PC, to decode over a valid/ready channel.
- Applies branch/jump redirects from execute and discards fetches that were in flight when the redirect arrived.
- Sits between the PC register path, the instruction memory port and the decode stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_out_buf.sv | 50 +++++
 rtl/fetch_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the instruction-fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int INSTR_W     = 32;

endpackage
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_out_buf
//  Brief    : One-entry valid/ready holding register for instruction + PC.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [XLEN-1:0]    load_pc,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [XLEN-1:0]    pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_data;
    logic [XLEN-1:0]    r_pc;

    // Flush beats both a same-cycle load and a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_pc    <= load_pc;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Fetch PC owner; one outstanding imem request, redirect + kill.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               instr_ready,
    output logic [XLEN-1:0]    pc
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;

    logic            w_buf_free;
    logic            w_req_fire;
    logic            w_load;
    logic [XLEN-1:0] w_target;

    assign w_target       = redirect_pc & ~XLEN'(3);
    assign w_buf_free     = !instr_valid || instr_ready;
    assign imem_req_valid = (r_state == REQ) && w_buf_free;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_load         = (r_state == WAIT) && imem_rsp_valid && !r_kill && !redirect_valid;
    assign pc             = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
            r_kill  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    if (redirect_valid) r_pc <= w_target;
                end
                REQ: begin
                    if (redirect_valid) r_pc <= w_target;
                    // An accepted old address must have its response discarded.
                    if (w_req_fire) begin
                        r_state <= WAIT;
                        r_kill  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= REQ;
                        r_kill  <= 1'b0;
                        if (redirect_valid)
                            r_pc <= w_target;
                        else if (!r_kill)
                            r_pc <= r_pc + XLEN'(INSTR_BYTES);
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                        r_pc   <= w_target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_out_buf #(
        .XLEN (XLEN)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .flush     (redirect_valid),
        .load_data (imem_rsp_data),
        .load_pc   (r_pc),
        .ready     (instr_ready),
        .valid     (instr_valid),
        .data      (instr_data),
        .pc        (instr_pc)
    );

endmodule
`default_nettype wire
